// File: rtl/prog_loader.sv
// prog_loader: assembles a byte stream into 16-bit words and writes them to instruction memory.
//   Optional checksum byte after the image: define PROG_LOADER_CHECKSUM_EN.
//   Ports: clk, rst (async, active high), start (load pulse),
//          in_valid/in_data/in_ready (byte stream handshake),
//          mem_writeEn/mem_writeAddr/mem_writeData (memory write port),
//          cpu_rst (CPU held in reset until an image is loaded),
//          busy/done/err (status), count (words written in this load).
module prog_loader #(
    parameter int IBW   = 16,
    parameter int AW    = 8,
    parameter int DEPTH = 50
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    input  logic [7:0]     in_data,
    output logic           in_ready,
    output logic           mem_writeEn,
    output logic [AW-1:0]  mem_writeAddr,
    output logic [IBW-1:0] mem_writeData,
    output logic           cpu_rst,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [AW-1:0]  count
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_DONE, S_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;
    state_t        r_state;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_count;
    logic [7:0]    r_hi;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]    r_sum;
`endif
    logic w_xfer, w_start_ok, w_last;
    assign w_xfer        = in_valid && in_ready;
    // start is honoured only from a resting state, so it cannot disturb a load
    assign w_start_ok    = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_last        = (r_count + AW'(1)) == r_len;
    assign count         = r_count;
    assign mem_writeAddr = r_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_count       <= '0;
            r_hi          <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum         <= '0;
`endif
            in_ready      <= 1'b0;
            mem_writeEn   <= 1'b0;
            mem_writeData <= '0;
            cpu_rst       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            mem_writeEn <= 1'b0;
            if (w_start_ok) begin
                r_state  <= S_LEN;
                r_count  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum    <= '0;
`endif
                in_ready <= 1'b1;
                cpu_rst  <= 1'b1;
                busy     <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
            end else begin
                case (r_state)
                    S_LEN: if (w_xfer) begin
                        r_len <= AW'(in_data);
                        if (in_data == 8'd0 || int'(in_data) > DEPTH) begin
                            r_state  <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            r_state <= S_HI;
                        end
                    end
                    S_HI: if (w_xfer) begin
                        r_hi    <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum   <= r_sum ^ in_data;
`endif
                        r_state <= S_LO;
                    end
                    S_LO: if (w_xfer) begin
                        mem_writeData <= {r_hi, in_data};
                        mem_writeEn   <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum         <= r_sum ^ in_data;
`endif
                        in_ready      <= 1'b0;
                        r_state       <= S_WRITE;
                    end
                    S_WRITE: begin
                        r_count <= r_count + AW'(1);
                        if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state  <= S_CHK;
                            in_ready <= 1'b1;
`else
                            r_state  <= S_DONE;
                            cpu_rst  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
`endif
                        end else begin
                            r_state  <= S_HI;
                            in_ready <= 1'b1;
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    S_CHK: if (w_xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == r_sum) begin
                            r_state <= S_DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory: takes a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words sequentially into the instruction memory write port (writeAddr/writeData/writeEn), starting at address 0.
- Holds the CPU in reset while loading and releases it only after a complete, legal image has been written.

Parameters:
- IBW, 16, instruction word width; must be 2*8.
- AW, 8, memory address width.
- DEPTH, 50, number of memory entries; the maximum legal word count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  byte source has data
- in_data  in  8  byte from source
- in_ready  out  1  loader accepts a byte this cycle
- mem_writeEn  out  1  memory write strobe
- mem_writeAddr  out  AW  memory write address
- mem_writeData  out  IBW  memory write data
- cpu_rst  out  1  reset to CPU; high whenever no complete image is loaded
- busy  out  1  load in progress
- done  out  1  image loaded; CPU running
- err  out  1  load aborted on an illegal length (or checksum)
- count  out  AW  words written so far in the current load

Behaviour:
- Byte transfer occurs only when in_valid && in_ready. in_data is ignored otherwise.
- Reset (asynchronous, any state, including mid-load) sets:
  - state=IDLE, cpu_rst=1, in_ready=0, mem_writeEn=0
  - mem_writeAddr=0, mem_writeData=0
  - busy=0, done=0, err=0, count=0, internal length N=0
- States:
  - IDLE: in_ready=0, cpu_rst=1. start -> LEN, with count=0 and err=0.
  - LEN: in_ready=1. On transfer, N=in_data.
    - If N==0 or N>DEPTH -> ERR.
    - Otherwise -> HI.
  - HI: in_ready=1. On transfer, latch the high byte -> LO.
  - LO: in_ready=1. On transfer, mem_writeData={hi,in_data} -> WRITE.
  - WRITE: in_ready=0. mem_writeEn=1 for exactly one cycle, with mem_writeAddr=count. Next cycle count increments.
    - If count+1==N -> DONE (or CHK with the optional feature).
    - Otherwise -> HI.
  - DONE: cpu_rst=0, done=1, in_ready=0. start -> LEN, with cpu_rst=1 and done=0 in the next cycle.
  - ERR: err=1, cpu_rst=1, in_ready=0. Only start or rst exits.
- busy=1 in LEN, HI, LO, WRITE and CHK.
- mem_writeEn is never asserted outside WRITE.
- mem_writeAddr equals count at all times.
- Byte-to-write latency: the write strobe is asserted the cycle after the low byte is accepted.
- Minimum load time: 1 + 3N cycles after the start cycle.
- cpu_rst is registered. It falls the cycle the FSM enters DONE and rises in the cycle after start is seen in DONE.
- start is ignored while busy=1.
- in_valid held high in IDLE, DONE or ERR is not consumed.
- count never exceeds N, so writes never exceed address DEPTH-1.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - After the last WRITE, the FSM enters CHK with in_ready=1 and accepts one byte.
  - If that byte equals the XOR of all 2N data bytes (length byte excluded) -> DONE; otherwise -> ERR.
  - Words already written remain in memory, and cpu_rst stays 1.
- When undefined: no CHK state; the last WRITE goes directly to DONE.

Test Plan:
- Reset then start; stream 02,12,34,D5,00 with in_valid always high -> writes (0,0x1234) and (1,0xD500); one mem_writeEn pulse each; done=1, cpu_rst=0, count=2.
- Length 00, then separately 33 (51 > DEPTH) -> err=1, no mem_writeEn pulse, cpu_rst=1, in_ready=0.
- Load N=3 with in_valid toggled randomly -> writes occur only after accepted low bytes, data/addresses exact, in_ready=0 in WRITE cycles.
- Assert rst after the 2nd word of an N=4 load -> all outputs at reset values immediately; a new start with N=1, bytes 10,FF -> (0,0x10FF), done=1.
- In DONE, pulse start -> cpu_rst=1 the next cycle; reload N=1 -> done again; start pulsed while busy has no effect.
- With PROG_LOADER_CHECKSUM_EN: N=1, 12,34, checksum 26 -> done=1; repeat with checksum 27 -> err=1, cpu_rst=1.
